// File: rtl/boot_loader_ctrl.sv
// Boot loader: streams a UART-delivered program into the 256x32 BRAM while the core
// is held in reset, then hands the BRAM port to the core and releases its reset.
module boot_loader_ctrl #(
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         TIMEOUT    = 1_000_000,
  parameter int         RESET_HOLD = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        core_memwe,
  input  logic [7:0]  core_memaddr,
  input  logic [31:0] core_memdin,
  output logic [31:0] core_memdout,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        core_rstn,
  output logic        done,
  output logic        err,
  output logic [8:0]  loaded_words
);

  localparam int GAP_W  = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, HOLD, RUN} state_t;

  state_t             state, state_next;
  logic [8:0]         n_words;
  logic [7:0]         word_idx;
  logic [1:0]         byte_idx;
  logic [31:0]        word_buf;
  logic [GAP_W-1:0]   gap_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               core_rstn_reg;
  logic               err_reg;
  logic               last_word;
  logic               timeout_hit;

  assign last_word   = ({1'b0, word_idx} == n_words - 9'd1);
  assign timeout_hit = (state == LOAD) && !rx_valid && (gap_cnt >= GAP_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (rx_valid) state_next = LOAD;
      LOAD: begin
        if (rx_valid && byte_idx == 2'd3) state_next = WRITE;
        else if (timeout_hit)             state_next = IDLE;
      end
      WRITE: state_next = last_word ? HOLD : LOAD;
      HOLD:  if (hold_cnt == HOLD_LAST) state_next = RUN;
      RUN:   state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: word assembly, counters and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_words       <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      word_buf      <= '0;
      gap_cnt       <= '0;
      hold_cnt      <= '0;
      loaded_words  <= '0;
      core_rstn_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg       <= timeout_hit;
      core_rstn_reg <= (state_next == RUN);
      case (state)
        IDLE: begin
          if (rx_valid) begin
            n_words      <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            word_idx     <= '0;
            byte_idx     <= '0;
            gap_cnt      <= '0;
            loaded_words <= '0;
          end
        end
        LOAD: begin
          if (rx_valid) begin
            word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
            byte_idx <= byte_idx + 2'd1;
            gap_cnt  <= '0;
          end else if (gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        WRITE: begin
          loaded_words <= loaded_words + 9'd1;
          hold_cnt     <= '0;
          // A byte landing during the write starts the next word; after the last word it is dropped.
          if (!last_word) begin
            word_idx <= word_idx + 8'd1;
            if (rx_valid) begin
              word_buf[7:0] <= rx_data;
              byte_idx      <= 2'd1;
              gap_cnt       <= '0;
            end
          end
        end
        HOLD: hold_cnt <= hold_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    done     = (state == RUN);
    mem_we   = (state == WRITE);
    mem_addr = BASE_ADDR + word_idx;
    mem_din  = word_buf;
    if (state == RUN) begin
      mem_we   = core_memwe;
      mem_addr = core_memaddr;
      mem_din  = core_memdin;
    end
  end

  assign core_memdout = mem_dout;
  assign core_rstn    = core_rstn_reg;
  assign err          = err_reg;

endmodule
